// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared types, Booth recoding constants and the round-robin
//               pick helper used by the shared sequential Booth multiplier.
//               Contents:
//                 state_t    - scheduler FSM states (IDLE, RUN, DONE)
//                 BOOTH_ADD  - {Qr[0],q0} pattern that adds the multiplicand
//                 BOOTH_SUB  - {Qr[0],q0} pattern that subtracts it
//                 MAX_NREQ   - upper bound on requesters handled by rr_pick
//                 rr_pick()  - first valid index at or after ptr, with wrap
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    localparam int MAX_NREQ = 32;

    // Returns the first index i (searching ptr, ptr+1, ... with wrap at nreq)
    // whose valid bit is set. Returns ptr when nothing is valid; callers
    // qualify the grant with the OR of the valid vector.
    function automatic int rr_pick(
        input logic [MAX_NREQ-1:0] valid,
        input int                  ptr,
        input int                  nreq
    );
        int   idx;
        logic found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            idx = ptr + k;
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            if (!found && (k < nreq) && valid[idx[4:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
// Module      : booth_step
// Description : One combinational radix-2 Booth iteration: optional add or
//               subtract of the multiplicand into the accumulator, followed
//               by an arithmetic right shift of {A, Qr, q0}.
// Ports       : i_a  [WIDTH:0]   accumulator (one guard bit)
//               i_qr [WIDTH-1:0] multiplier / low product bits
//               i_q0             previously shifted-out multiplier bit
//               i_mr [WIDTH:0]   sign-extended multiplicand
//               o_a, o_qr, o_q0  register values after this iteration
// Revision    : 1.0 - initial release
// ============================================================================
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_qr,
    input  logic             i_q0,
    input  logic [WIDTH:0]   i_mr,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_qr,
    output logic             o_q0
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum = i_a;
        case ({i_qr[0], i_q0})
            BOOTH_ADD: w_sum = i_a + i_mr;
            BOOTH_SUB: w_sum = i_a - i_mr;
            default:   w_sum = i_a;
        endcase
        // Arithmetic shift: the accumulator's sign bit is replicated, the
        // accumulator LSB moves into Qr and the Qr LSB becomes the new q0.
        o_a  = {w_sum[WIDTH], w_sum[WIDTH:1]};
        o_qr = {w_sum[0], i_qr[WIDTH-1:1]};
        o_q0 = i_qr[0];
    end

endmodule
`default_nettype wire

// File: rtl/booth_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_sched
// Description : Shared sequential radix-2 Booth multiplier serving NREQ
//               requesters. A round-robin arbiter accepts one signed
//               WIDTH x WIDTH operation at a time; one Booth step is done per
//               clock and the product is returned on a valid/ready channel
//               tagged with the owning requester index.
// Ports       : clk, rst                synchronous active-high reset
//               req_valid/req_ready     per-requester handshake (NREQ bits)
//               req_m, req_q            packed operands, slice i = requester i
//               res_valid/res_ready     result handshake
//               res_product [2*WIDTH]   signed product M*Q (registered)
//               res_id      [IDW]       owner of res_product (registered)
//               busy                    high while an operation is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_sched
    import booth_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_m,
    input  logic [NREQ*WIDTH-1:0] req_q,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*WIDTH-1:0]    res_product,
    output logic [IDW-1:0]        res_id,
    output logic                  busy
);

    localparam int             CW           = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  c_last_step  = CW'(WIDTH - 1);
    localparam logic [IDW-1:0] c_last_id    = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] c_one_hot0  = {{(NREQ-1){1'b0}}, 1'b1};

    // Registered state
    state_t             r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [CW-1:0]      r_count;
    logic [WIDTH:0]     r_a;
    logic [WIDTH-1:0]   r_qr;
    logic               r_q0;
    logic [WIDTH:0]     r_mr;
    logic [IDW-1:0]     r_owner;
    logic [2*WIDTH-1:0] r_res_product;
    logic [IDW-1:0]     r_res_id;

    // Next-state values
    state_t             w_state_nxt;
    logic [IDW-1:0]     w_rr_ptr_nxt;
    logic [CW-1:0]      w_count_nxt;
    logic [WIDTH:0]     w_a_nxt;
    logic [WIDTH-1:0]   w_qr_nxt;
    logic               w_q0_nxt;
    logic [WIDTH:0]     w_mr_nxt;
    logic [IDW-1:0]     w_owner_nxt;
    logic [2*WIDTH-1:0] w_res_product_nxt;
    logic [IDW-1:0]     w_res_id_nxt;

    // Arbitration and operand selection
    logic [MAX_NREQ-1:0] w_valid_ext;
    logic [IDW-1:0]      w_grant;
    logic                w_any_valid;
    logic [WIDTH-1:0]    w_sel_m;
    logic [WIDTH-1:0]    w_sel_q;

    // Booth step outputs
    logic [WIDTH:0]      w_a_step;
    logic [WIDTH-1:0]    w_qr_step;
    logic                w_q0_step;

    always_comb begin
        w_valid_ext             = '0;
        w_valid_ext[NREQ-1:0]   = req_valid;
    end

    assign w_any_valid = |req_valid;
    assign w_grant     = IDW'(rr_pick(w_valid_ext, int'(r_rr_ptr), NREQ));
    assign w_sel_m     = req_m[w_grant*WIDTH +: WIDTH];
    assign w_sel_q     = req_q[w_grant*WIDTH +: WIDTH];

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_a  (r_a),
        .i_qr (r_qr),
        .i_q0 (r_q0),
        .i_mr (r_mr),
        .o_a  (w_a_step),
        .o_qr (w_qr_step),
        .o_q0 (w_q0_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_count       <= '0;
            r_a           <= '0;
            r_qr          <= '0;
            r_q0          <= 1'b0;
            r_mr          <= '0;
            r_owner       <= '0;
            r_res_product <= '0;
            r_res_id      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_count       <= w_count_nxt;
            r_a           <= w_a_nxt;
            r_qr          <= w_qr_nxt;
            r_q0          <= w_q0_nxt;
            r_mr          <= w_mr_nxt;
            r_owner       <= w_owner_nxt;
            r_res_product <= w_res_product_nxt;
            r_res_id      <= w_res_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_count_nxt       = r_count;
        w_a_nxt           = r_a;
        w_qr_nxt          = r_qr;
        w_q0_nxt          = r_q0;
        w_mr_nxt          = r_mr;
        w_owner_nxt       = r_owner;
        w_res_product_nxt = r_res_product;
        w_res_id_nxt      = r_res_id;
        req_ready         = '0;

        case (r_state)
            IDLE: begin
                // Grant is only offered in IDLE; a valid grant is an
                // immediate accept because the granted requester is valid.
                if (w_any_valid) begin
                    req_ready   = c_one_hot0 << w_grant;
                    w_a_nxt     = '0;
                    w_qr_nxt    = w_sel_q;
                    w_q0_nxt    = 1'b0;
                    w_mr_nxt    = {w_sel_m[WIDTH-1], w_sel_m};
                    w_count_nxt = '0;
                    w_owner_nxt = w_grant;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_a_nxt     = w_a_step;
                w_qr_nxt    = w_qr_step;
                w_q0_nxt    = w_q0_step;
                w_count_nxt = r_count + 1'b1;
                if (r_count == c_last_step) begin
                    // Capture the result from the final step directly so the
                    // output registers are valid on the first DONE cycle.
                    w_res_product_nxt = {w_a_step[WIDTH-1:0], w_qr_step};
                    w_res_id_nxt      = r_owner;
                    w_state_nxt       = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_rr_ptr_nxt = (r_owner == c_last_id) ? '0 : r_owner + 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign res_valid   = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign res_product = r_res_product;
    assign res_id      = r_res_id;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mul_sched
// Description : Self-checking bench for booth_mul_sched (WIDTH=4, NREQ=2).
//               Expected products come from plain signed integer arithmetic;
//               expected grants come from a transaction-level round-robin
//               pointer that advances on each completed result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mul_sched;

    localparam int WIDTH = 4;
    localparam int NREQ  = 2;
    localparam int IDW   = 1;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_m;
    logic [NREQ*WIDTH-1:0] req_q;
    logic                  res_valid;
    logic                  res_ready;
    logic [2*WIDTH-1:0]    res_product;
    logic [IDW-1:0]        res_id;
    logic                  busy;

    int n_vec;
    int n_err;
    int cyc;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] q;
        logic [7:0]       exp;
    } vec_t;

    vec_t tbl[6];

    booth_mul_sched #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_m       (req_m),
        .req_q       (req_q),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_product (res_product),
        .res_id      (res_id),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_mul(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        int mi;
        int qi;
        int p;
        mi = int'($signed(m));
        qi = int'($signed(q));
        p  = mi * qi;
        return p[7:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Single-requester operation: checks grant, latency, product, tag,
    // hold under backpressure for 'delay' cycles, and return to IDLE.
    // Operands are scrambled right after accept.
    task automatic do_op(input int id, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q,
                         input logic [7:0] exp, input int delay, input string nm);
        int k;
        int lat;
        logic [7:0]     held_p;
        logic [IDW-1:0] held_id;
        req_m[id*WIDTH +: WIDTH] = m;
        req_q[id*WIDTH +: WIDTH] = q;
        req_valid = 2'(1 << id);
        res_ready = (delay == 0);
        #1;
        k = 0;
        while (req_ready != 2'(1 << id) && k < 50) begin
            tick();
            k++;
        end
        chk({nm, "_ready"}, 32'(req_ready), 32'(1 << id));
        tick();
        req_valid = '0;
        req_m     = 8'($urandom);
        req_q     = 8'($urandom);
        lat = 1;
        while (!res_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(WIDTH + 1));
        chk({nm, "_product"}, 32'(res_product), 32'(exp));
        chk({nm, "_id"}, 32'(res_id), 32'(id));
        held_p  = res_product;
        held_id = res_id;
        for (int i = 0; i < delay; i++) begin
            req_valid = '1;
            tick();
            #1;
            chk({nm, "_hold_valid"}, 32'(res_valid), 32'd1);
            chk({nm, "_hold_product"}, 32'(res_product), 32'(held_p));
            chk({nm, "_hold_id"}, 32'(res_id), 32'(held_id));
            chk({nm, "_hold_busy"}, 32'(busy), 32'd1);
            chk({nm, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = '0;
        res_ready = 1'b1;
        tick();
        chk({nm, "_idle_valid"}, 32'(res_valid), 32'd0);
        chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        int model_rr;
        int last_acc;
        logic [7:0] exp;
        int rid;
        logic [WIDTH-1:0] rm;
        logic [WIDTH-1:0] rq;

        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_m     = '0;
        req_q     = '0;
        res_ready = 1'b1;

        // Reset state
        do_reset();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_product", 32'(res_product), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);

        // Directed corner vectors
        tbl[0] = '{id: 0, m: 4'd3,  q: 4'hE, exp: 8'hFA};
        tbl[1] = '{id: 0, m: 4'h8,  q: 4'h8, exp: 8'h40};
        tbl[2] = '{id: 1, m: 4'h8,  q: 4'h7, exp: 8'hC8};
        tbl[3] = '{id: 1, m: 4'h7,  q: 4'h7, exp: 8'h31};
        tbl[4] = '{id: 0, m: 4'h0,  q: 4'h8, exp: 8'h00};
        tbl[5] = '{id: 1, m: 4'h9,  q: 4'h6, exp: 8'hD6};
        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].id, tbl[i].m, tbl[i].q, tbl[i].exp, 0, $sformatf("vec%0d", i));
        end

        // Randomized single-requester ops with random result backpressure
        for (int i = 0; i < 16; i++) begin
            rid = int'($urandom_range(0, 1));
            rm  = 4'($urandom);
            rq  = 4'($urandom);
            do_op(rid, rm, rq, ref_mul(rm, rq), int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end

        // Backpressure: 10 cycles of res_ready=0 while DONE
        do_op(1, 4'h5, 4'hD, ref_mul(4'h5, 4'hD), 10, "bp");

        // Contention: both requesters valid continuously
        do_reset();
        req_m     = {4'hF, 4'h2};
        req_q     = {4'h5, 4'h3};
        req_valid = 2'b11;
        res_ready = 1'b1;
        model_rr  = 0;
        last_acc  = 0;
        #1;
        for (int n = 0; n < 4; n++) begin
            k = 0;
            while (req_ready == '0 && k < 50) begin
                tick();
                k++;
            end
            chk($sformatf("rr%0d_grant", n), 32'(req_ready), 32'(1 << model_rr));
            if (n > 0) begin
                chk($sformatf("rr%0d_gap", n), 32'(cyc - last_acc), 32'd6);
            end
            last_acc = cyc;
            tick();
            k = 0;
            while (!res_valid && k < 50) begin
                tick();
                k++;
            end
            exp = (model_rr == 0) ? ref_mul(4'h2, 4'h3) : ref_mul(4'hF, 4'h5);
            chk($sformatf("rr%0d_product", n), 32'(res_product), 32'(exp));
            chk($sformatf("rr%0d_id", n), 32'(res_id), 32'(model_rr));
            model_rr = (model_rr + 1) % NREQ;
            tick();
        end
        req_valid = '0;
        tick();

        // Reset during the second RUN cycle
        do_reset();
        do_op(0, 4'h2, 4'h2, 8'h04, 0, "pre_abort");
        req_m     = {4'h5, 4'h5};
        req_q     = {4'h5, 4'h5};
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        req_valid = 2'b11;
        #1;
        chk("abort_rr_ptr", 32'(req_ready), 32'd1);
        req_valid = '0;
        k = 0;
        for (int i = 0; i < WIDTH + 3; i++) begin
            tick();
            if (res_valid) k++;
        end
        chk("abort_no_result", 32'(k), 32'd0);
        do_op(0, 4'h3, 4'h3, 8'h09, 0, "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/booth_mul_sched.md
Name: booth_mul_sched

Overview:
- Shared, sequential radix-2 Booth multiplier serving NREQ requesters.
- Round-robin arbiter grants one signed WIDTH x WIDTH multiply at a time.
- An FSM performs one Booth add/sub-and-shift step per clock.
- Result is returned on a single valid/ready output channel tagged with the requester index.
- Sits between several datapath clients and one multiplier resource, replacing per-client combinational multipliers.

Parameters:
- WIDTH, 4, operand width in bits (two's complement); product is 2*WIDTH bits.
- NREQ, 2, number of requesters (>=2).
- IDW, $clog2(NREQ), width of the requester-index tag.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_m  in  NREQ*WIDTH  multiplicands, slice i = requester i, signed.
- req_q  in  NREQ*WIDTH  multipliers, slice i = requester i, signed.
- res_valid  out  1  product available.
- res_ready  in  1  consumer accepts product.
- res_product  out  2*WIDTH  signed product M*Q.
- res_id  out  IDW  index of the requester that owns res_product.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, count=0.
  - res_valid=0, res_product=0, res_id=0, busy=0, req_ready=0.
  - Reset overrides everything, including mid-RUN or DONE; the in-flight operation is discarded and no result is emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0. No valid requests means req_ready=0.
  - On the handshake (req_valid[g] & req_ready[g]), load the working registers:
    - A = 0 (WIDTH+1 bits).
    - Qr = req_q[g]; q0 = 0.
    - Mr = req_m[g], sign-extended to WIDTH+1 bits.
    - count = 0; owner = g; then go to RUN.
- RUN, one step per cycle:
  - {Qr[0],q0}=01 → A=A+Mr; 10 → A=A-Mr; 00/11 → no change.
  - Then arithmetic-shift {A,Qr,q0} right by 1, replicating the sign of A.
  - count++. After the step where count reaches WIDTH-1 (i.e., WIDTH steps total), go to DONE.
  - The WIDTH+1-bit accumulator keeps Mr = -2^(WIDTH-1) exact; no overflow for any operand pair.
- DONE:
  - res_valid=1; res_product={A[WIDTH-1:0],Qr}; res_id=owner.
  - All outputs are held stable while res_ready=0 (no timeout).
  - On res_valid & res_ready: go to IDLE, rr_ptr=(owner+1) mod NREQ, res_valid=0.
- req_ready=0 in RUN and DONE. A requester keeps valid high until accepted.
- Operands are sampled only at accept; later changes to req_m/req_q have no effect.
- Latency: accept handshake in cycle 0 → RUN in cycles 1..WIDTH → res_valid first high in cycle WIDTH+1.
- Throughput: the next accept is possible no earlier than the cycle after the result handshake, i.e. at best one result per WIDTH+2 cycles.
- Simultaneous requests: exactly one is granted by round-robin. Losers see req_ready=0 and retry automatically.
- rr_ptr advances only on result completion, not on accept.
- res_product and res_id are registered, with no combinational path from req_* to res_*.

Decomposition:
- Package booth_pkg:
  - state enum (IDLE, RUN, DONE).
  - booth-code constants (BOOTH_ADD=2'b01, BOOTH_SUB=2'b10).
  - function rr_pick(valid, ptr) returning the grant index.
- Sub-module booth_step:
  - Purely combinational single iteration.
  - Inputs: A, Qr, q0, Mr. Outputs: next A, Qr, q0.
  - Instantiated once inside the FSM, and unit-testable on its own.

Test Plan:
- Req0 only, M=3, Q=-2: req_ready[0] in cycle 0, res_valid in cycle 5, res_product=8'hFA (-6), res_id=0.
- Corner operands:
  - M=-8, Q=-8 → 8'h40 (64).
  - M=-8, Q=7 → 8'hC8 (-56).
  - M=7, Q=7 → 8'h31 (49).
  - M=0, Q=-8 → 8'h00.
- Both requesters valid every cycle (req0: 2*3, req1: -1*5):
  - Grants alternate 0,1,0,1.
  - Results alternate 8'h06/id0 and 8'hFB/id1.
  - A new accept occurs every 6 cycles when res_ready=1.
- Backpressure: res_ready=0 for 10 cycles in DONE:
  - res_valid, res_product, res_id held constant; busy=1; req_ready=0.
  - Raising res_ready completes in that cycle; IDLE on the next.
- rst=1 in the 2nd RUN cycle:
  - Next cycle: IDLE, res_valid=0, busy=0, rr_ptr=0.
  - No result is emitted for the aborted op; a fresh 3*3 then yields 8'h09.
- Operand change after accept: req_m/req_q altered during RUN → the product still reflects the values sampled at accept.
